button_event_gen: RTL and testbench

//  Consumes the debouncer's clean level and turns it into discrete single-cycle events for the FIFO

---
 rtl/button_event_gen_pkg.sv | 13 +
 rtl/button_event_gen.sv | 116 +++++++++++
 tb/tb_button_event_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/button_event_gen_pkg.sv
// Shared state encodings and widths for the button event generator
// and the other button-handling blocks.
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HOLD = 2'd1,
    ST_REPEAT    = 2'd2
  } state_e;

  localparam int unsigned EVT_W = 8;

endpackage

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press, auto-repeat and release
// pulses plus a held level and a wrapping press counter.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 2500,
  parameter int unsigned REPEAT_CYCLES = 500,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned CNT_W         = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             debounced_button,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             held,
  output logic [EVT_W-1:0] event_count
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               btn_prev_q, btn_prev_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               held_q, held_d;
  logic [EVT_W-1:0]   count_q, count_d;
  logic               rise;

  assign rise = debounced_button & ~btn_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    btn_prev_d = debounced_button;
    press_d    = 1'b0;
    release_d  = 1'b0;
    held_d     = held_q;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: begin
        held_d = 1'b0;
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_HOLD;
        end
      end
      ST_WAIT_HOLD: begin
        if (!debounced_button) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          // without auto-repeat the counter just parks here
          if (REPEAT_EN) begin
            press_d = 1'b1;
            held_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!debounced_button) begin
          release_d = 1'b1;
          held_d    = 1'b0;
          state_d   = ST_IDLE;
        end else if (cnt_q == REP_LAST) begin
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
    if (press_d) begin
      count_d = count_q + 1'b1;
    end
  end

  // btn_prev resets high so a button held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      btn_prev_q <= 1'b1;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      held_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_prev_d;
      press_q    <= press_d;
      release_q  <= release_d;
      held_q     <= held_d;
      count_q    <= count_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign held          = held_q;
  assign event_count   = count_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: repeat-enabled and repeat-disabled
// instances share one button; pulse timing checked via queues.
module tb_button_event_gen;

  localparam int H = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       pa, ra, ha;
  logic       pb, rb, hb;
  logic [7:0] ca, cb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int qpa[$];
  int qra[$];
  int qpb[$];
  int qrb[$];
  logic [7:0] exp_ca = 8'd0;
  logic [7:0] exp_cb = 8'd0;

  typedef struct {
    int   hi;
    int   lo;
    logic held_end;
    int   npress;
  } vec_t;

  vec_t vecs[7];

  button_event_gen #(
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
    .REPEAT_EN(1'b1), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .debounced_button(btn),
    .press_pulse(pa), .release_pulse(ra),
    .held(ha), .event_count(ca)
  );

  button_event_gen #(
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
    .REPEAT_EN(1'b0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst),
    .debounced_button(btn),
    .press_pulse(pb), .release_pulse(rb),
    .held(hb), .event_count(cb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic unexp(string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected pulse at cyc %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    chk("excl_a", int'(pa && ra), 0);
    chk("excl_b", int'(pb && rb), 0);
    if (pa) begin
      if (qpa.size() == 0) unexp("press_a");
      else chk("press_a_cyc", cyc, qpa.pop_front());
    end
    if (ra) begin
      if (qra.size() == 0) unexp("release_a");
      else chk("release_a_cyc", cyc, qra.pop_front());
    end
    if (pb) begin
      if (qpb.size() == 0) unexp("press_b");
      else chk("press_b_cyc", cyc, qpb.pop_front());
    end
    if (rb) begin
      if (qrb.size() == 0) unexp("release_b");
      else chk("release_b_cyc", cyc, qrb.pop_front());
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(vec_t v);
    int c;
    c = cyc;
    btn = 1'b1;
    qpa.push_back(c + 1);
    qpb.push_back(c + 1);
    for (int k = H; k <= v.hi - 1; k += R) begin
      qpa.push_back(c + 1 + k);
    end
    exp_ca = exp_ca + 8'(v.npress);
    exp_cb = exp_cb + 8'd1;
    tick(v.hi);
    chk("held_a", int'(ha), int'(v.held_end));
    chk("held_b", int'(hb), 0);
    btn = 1'b0;
    qra.push_back(c + v.hi + 1);
    qrb.push_back(c + v.hi + 1);
    tick(v.lo);
    chk("held_a_rel", int'(ha), 0);
    chk("count_a", int'(ca), int'(exp_ca));
    chk("count_b", int'(cb), int'(exp_cb));
  endtask

  initial begin
    vec_t one;
    vecs[0] = '{hi: 5,  lo: 3, held_end: 1'b0, npress: 1};
    vecs[1] = '{hi: 20, lo: 3, held_end: 1'b1, npress: 4};
    vecs[2] = '{hi: 12, lo: 3, held_end: 1'b1, npress: 2};
    vecs[3] = '{hi: 9,  lo: 3, held_end: 1'b1, npress: 2};
    vecs[4] = '{hi: 8,  lo: 1, held_end: 1'b0, npress: 1};
    vecs[5] = '{hi: 4,  lo: 2, held_end: 1'b0, npress: 1};
    vecs[6] = '{hi: 30, lo: 3, held_end: 1'b1, npress: 7};

    rst = 1'b1;
    btn = 1'b0;
    tick(3);
    chk("rst_press_a", int'(pa), 0);
    chk("rst_rel_a", int'(ra), 0);
    chk("rst_held_a", int'(ha), 0);
    chk("rst_count_a", int'(ca), 0);
    chk("rst_count_b", int'(cb), 0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 7; i++) begin
      press(vecs[i]);
    end

    // button held through reset: no event until a fresh rise
    btn = 1'b1;
    qpa.push_back(cyc + 1);
    qpb.push_back(cyc + 1);
    tick(4);
    rst = 1'b1;
    tick(3);
    chk("midrst_count_a", int'(ca), 0);
    chk("midrst_count_b", int'(cb), 0);
    chk("midrst_held_a", int'(ha), 0);
    exp_ca = 8'd0;
    exp_cb = 8'd0;
    rst = 1'b0;
    tick(12);
    chk("hold_after_rst_a", int'(ca), 0);
    btn = 1'b0;
    tick(2);
    chk("low_after_rst_a", int'(ca), 0);
    chk("low_after_rst_b", int'(cb), 0);
    one = '{hi: 3, lo: 2, held_end: 1'b0, npress: 1};
    press(one);
    chk("repress_count_a", int'(ca), 1);

    // event counter wrap over 256 minimal presses
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_ca = 8'd0;
    exp_cb = 8'd0;
    tick(2);
    one = '{hi: 1, lo: 1, held_end: 1'b0, npress: 1};
    for (int i = 0; i < 256; i++) begin
      press(one);
      if (i == 254) begin
        chk("count_255_b", int'(cb), 255);
      end
    end
    chk("wrap_a", int'(ca), 0);
    chk("wrap_b", int'(cb), 0);

    tick(3);
    chk("left_press_a", qpa.size(), 0);
    chk("left_rel_a", qra.size(), 0);
    chk("left_press_b", qpb.size(), 0);
    chk("left_rel_b", qrb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
